// File: rtl/tub_scan_driver_pkg.sv
// Shared definitions for the 8-digit, two-group 7-segment scan driver.
//   DIGITS       number of multiplexed digits
//   GROUP_SPLIT  first digit index driven on the left-group bus
//   IDX_W        width of a digit index
//   IDX_FIRST    index of the leftmost digit, scanned first in every frame
//   seg_t        one segment code, active-high, bit 7 = dp
//   sel_onehot   digit index to one-hot select pattern
package tub_scan_driver_pkg;

   localparam int DIGITS      = 8;
   localparam int GROUP_SPLIT = 4;
   localparam int IDX_W       = $clog2(DIGITS);

   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DIGITS - 1);

   typedef logic [7:0] seg_t;

   function automatic seg_t sel_onehot(input logic [IDX_W-1:0] idx);
      return seg_t'(1) << idx;
   endfunction

endpackage

// File: rtl/tub_slot_timer.sv
// Slot timer for the scan driver: slot counter, digit index and snapshot strobe.
//   sys_clk  system clock, rising edge
//   rst_n    asynchronous active-low reset
//   en_i     display enable; while low the counter parks at 0 and the index at 7
//   cnt_o    position inside the current digit slot, 0..SCAN_DIV-1
//   idx_o    digit currently owning the slot, 7 down to 0
//   snap_o   combinational: this cycle starts a frame (slot 0 of digit 7, enabled)
module tub_slot_timer
   import tub_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int CNT_W    = $clog2(SCAN_DIV)
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             snap_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en_i) begin
         cnt_d = '0;
         idx_d = IDX_FIRST;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == '0) ? IDX_FIRST : idx_q - IDX_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= IDX_FIRST;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Parking at (0, 7) while disabled makes the enable-rise snapshot fall out
   // of the same condition as the regular frame boundary.
   assign snap_o = en_i && (cnt_q == '0) && (idx_q == IDX_FIRST);
   assign cnt_o  = cnt_q;
   assign idx_o  = idx_q;

endmodule

// File: rtl/tub_scan_driver.sv
// Time-multiplexed driver for the 8-digit, two-group 7-segment display.
// Latches a frame-coherent snapshot of the digit codes, blinks selected
// digits, limits the lit window per slot for brightness and keeps an all-off
// dead time at the start of every slot. All outputs are registered.
//   sys_clk      system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data7..0     segment codes, data7 = leftmost digit
//   en           display enable
//   blink_mask   bit i set: digit i blinks
//   bright       lit for (bright+1)/4 of the slot
//   tub_sel      one-hot digit select, active-high
//   tub_data1    segments for digits 7..4
//   tub_data2    segments for digits 3..0
//   frame_start  one-cycle pulse following each snapshot
module tub_scan_driver
   import tub_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int DEAD_CYC     = 2000,
   parameter int BLINK_FRAMES = 63
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [7:0] data7,
   input  logic [7:0] data6,
   input  logic [7:0] data5,
   input  logic [7:0] data4,
   input  logic [7:0] data3,
   input  logic [7:0] data2,
   input  logic [7:0] data1,
   input  logic [7:0] data0,
   input  logic       en,
   input  logic [7:0] blink_mask,
   input  logic [1:0] bright,
   output logic [7:0] tub_sel,
   output logic [7:0] tub_data1,
   output logic [7:0] tub_data2,
   output logic       frame_start
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int WIN_W = CNT_W + 2;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [WIN_W-1:0] WIN_DEAD    = WIN_W'(DEAD_CYC);
   localparam logic [WIN_W-1:0] WIN_QUARTER = WIN_W'(SCAN_DIV / 4);
   localparam logic [WIN_W-1:0] WIN_SLOT    = WIN_W'(SCAN_DIV);
   localparam logic [BLK_W-1:0] BLK_LAST    = BLK_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             snap;

   tub_slot_timer #(
      .SCAN_DIV (SCAN_DIV),
      .CNT_W    (CNT_W)
   ) u_slot_timer (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .cnt_o   (cnt),
      .idx_o   (idx),
      .snap_o  (snap)
   );

   seg_t [DIGITS-1:0] data_in;
   assign data_in = {data7, data6, data5, data4, data3, data2, data1, data0};

   seg_t [DIGITS-1:0] shadow_q, shadow_d;
   logic [DIGITS-1:0] blink_q, blink_d;
   logic [1:0]        bright_q, bright_d;
   logic [BLK_W-1:0]  bcnt_q, bcnt_d;
   logic              phase_q, phase_d;
   logic              phase_s_q, phase_s_d;

   logic [WIN_W-1:0]  win_hi;
   logic [WIN_W-1:0]  win_cnt;
   logic              lit;

   seg_t              tub_sel_q, tub_sel_d;
   seg_t              tub_data1_q, tub_data1_d;
   seg_t              tub_data2_q, tub_data2_d;
   logic              frame_start_q, frame_start_d;

   // Snapshot and blink bookkeeping. The *_d values double as the frame's
   // effective settings, so the snapshot cycle itself already sees fresh data.
   // phase_s freezes the phase as it stood when the frame began, so a toggle
   // only becomes visible from the following frame on.
   always_comb begin
      shadow_d  = shadow_q;
      blink_d   = blink_q;
      bright_d  = bright_q;
      bcnt_d    = bcnt_q;
      phase_d   = phase_q;
      phase_s_d = phase_s_q;
      if (snap) begin
         shadow_d  = data_in;
         blink_d   = blink_mask;
         bright_d  = bright;
         phase_s_d = phase_q;
         if (bcnt_q == BLK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d  = bcnt_q + BLK_W'(1);
         end
      end
   end

   // Lit window, evaluated two bits wider than the counter so the upper
   // bound cannot wrap before it is clamped to the slot length.
   always_comb begin
      win_hi  = WIN_DEAD + WIN_W'({1'b0, bright_d} + 3'd1) * WIN_QUARTER;
      if (win_hi > WIN_SLOT) begin
         win_hi = WIN_SLOT;
      end
      win_cnt = WIN_W'(cnt);
      lit     = (win_cnt >= WIN_DEAD) && (win_cnt < win_hi) &&
                !(blink_d[idx] && !phase_s_d);
   end

   // Select and data are registered together, so a select never sees its
   // data bus change underneath it.
   always_comb begin
      tub_sel_d     = '0;
      tub_data1_d   = '0;
      tub_data2_d   = '0;
      frame_start_d = snap;
      if (en && lit) begin
         tub_sel_d = sel_onehot(idx);
         if (idx >= IDX_W'(GROUP_SPLIT)) begin
            tub_data1_d = shadow_d[idx];
         end else begin
            tub_data2_d = shadow_d[idx];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q      <= '0;
         blink_q       <= '0;
         bright_q      <= '0;
         bcnt_q        <= '0;
         phase_q       <= 1'b1;
         phase_s_q     <= 1'b1;
         tub_sel_q     <= '0;
         tub_data1_q   <= '0;
         tub_data2_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         blink_q       <= blink_d;
         bright_q      <= bright_d;
         bcnt_q        <= bcnt_d;
         phase_q       <= phase_d;
         phase_s_q     <= phase_s_d;
         tub_sel_q     <= tub_sel_d;
         tub_data1_q   <= tub_data1_d;
         tub_data2_q   <= tub_data2_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign tub_sel     = tub_sel_q;
   assign tub_data1   = tub_data1_q;
   assign tub_data2   = tub_data2_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tub_scan_driver.sv
module tb_tub_scan_driver;

   localparam int SD    = 16;
   localparam int DEAD  = 2;
   localparam int BF    = 2;
   localparam int FRAME = 8 * SD;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] din [8];
   logic [7:0] mask;
   logic [1:0] bright;
   logic [7:0] sel, d1, d2;
   logic       fs;

   int n_checks = 0;
   int n_pass   = 0;

   tub_scan_driver #(
      .SCAN_DIV     (SD),
      .DEAD_CYC     (DEAD),
      .BLINK_FRAMES (BF)
   ) dut (
      .sys_clk     (clk),
      .rst_n       (rst_n),
      .data7       (din[7]),
      .data6       (din[6]),
      .data5       (din[5]),
      .data4       (din[4]),
      .data3       (din[3]),
      .data2       (din[2]),
      .data1       (din[1]),
      .data0       (din[0]),
      .en          (en),
      .blink_mask  (mask),
      .bright      (bright),
      .tub_sel     (sel),
      .tub_data1   (d1),
      .tub_data2   (d2),
      .frame_start (fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Position is tracked as enabled time since the scan (re)started; slot,
   // digit and frame follow from division. Blink visibility of a frame is the
   // parity of (frames snapshotted so far / BF).
   int         m_t, m_snaps, m_br;
   logic [7:0] m_sh [8];
   logic [7:0] m_mask;
   bit         m_vis;
   logic [24:0] m_exp;

   task automatic model_reset();
      m_t = 0; m_snaps = 0; m_br = 0; m_mask = 0; m_vis = 1;
      for (int i = 0; i < 8; i++) m_sh[i] = 0;
   endtask

   task automatic model_step(output logic [24:0] e);
      int c, idx, hi;
      bit lit;
      e = '0;
      if (!en) begin
         m_t = 0;
      end else begin
         c   = m_t % SD;
         idx = 7 - (m_t / SD);
         if (m_t == 0) begin
            for (int i = 0; i < 8; i++) m_sh[i] = din[i];
            m_mask = mask;
            m_br   = int'(bright);
            m_vis  = ((m_snaps / BF) % 2) == 0;
            m_snaps++;
            e[0] = 1'b1;
         end
         hi = DEAD + (m_br + 1) * (SD / 4);
         if (hi > SD) hi = SD;
         lit = (c >= DEAD) && (c < hi) && !(m_mask[idx] && !m_vis);
         if (lit) begin
            e[24:17] = 8'(1 << idx);
            if (idx >= 4) e[16:9] = m_sh[idx];
            else          e[8:1]  = m_sh[idx];
         end
         m_t = (m_t + 1) % FRAME;
      end
   endtask

   initial model_reset();

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
         m_exp = '0;
      end else begin
         model_step(m_exp);
      end
      #1;
      check("model", {7'd0, sel, d1, d2, fs}, {7'd0, m_exp});
   end

   // ---------------- helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_data(input logic [7:0] c7, input logic [7:0] c0);
      for (int i = 0; i < 8; i++) din[i] = 8'h00;
      din[7] = c7;
      din[0] = c0;
   endtask

   // Runs nfr frames from a fresh start: exact checks on the first slot,
   // frame_start every frame, lit-cycle counts for digits 7 and 0 per frame.
   task automatic run_frames(input int nfr, input bit blink);
      int c7 [6];
      int c0 [6];
      int f;
      for (int i = 0; i < 6; i++) begin c7[i] = 0; c0[i] = 0; end
      for (int n = 1; n <= nfr * FRAME; n++) begin
         cyc(1);
         f = (n - 1) / FRAME;
         if (n <= 17) begin
            check("first_slot_sel", {24'd0, sel}, (n >= 3 && n <= 16) ? 32'h80 : 32'h0);
            check("first_slot_d1",  {24'd0, d1},  (n >= 3 && n <= 16) ? 32'h76 : 32'h0);
            check("first_slot_d2",  {24'd0, d2},  32'h0);
         end
         check("frame_start", {31'd0, fs}, ((n - 1) % FRAME) == 0 ? 32'd1 : 32'd0);
         if (sel == 8'h80 && d1 == 8'h76) c7[f]++;
         if (sel == 8'h01 && d2 == 8'h3F) c0[f]++;
      end
      for (int i = 0; i < nfr; i++) begin
         check("digit7_lit_cycles", c7[i], 14);
         if (blink) check("digit0_blink_cycles", c0[i], ((i / 2) % 2 == 0) ? 14 : 0);
      end
   endtask

   typedef struct {
      int         digit;
      logic [7:0] code;
      logic [1:0] bright;
      int         exp_first;
      int         exp_count;
      bit         left;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int         first, cnt;
      logic [7:0] exp_sel;
      bit         hit;

      vecs[0] = '{7, 8'h76, 2'd3,   3, 14, 1'b1};
      vecs[1] = '{0, 8'h3F, 2'd0, 115,  4, 1'b0};
      vecs[2] = '{4, 8'h66, 2'd1,  51,  8, 1'b1};
      vecs[3] = '{3, 8'h4F, 2'd2,  67, 12, 1'b0};
      vecs[4] = '{5, 8'h6D, 2'd3,  35, 14, 1'b1};
      vecs[5] = '{1, 8'h06, 2'd2,  99, 12, 1'b0};

      // reset and first frame
      rst_n = 1'b1; en = 1'b1; mask = 8'h00; bright = 2'd3;
      set_data(8'h76, 8'h00);
      #1 rst_n = 1'b0;
      cyc(2);
      check("reset_state", {7'd0, sel, d1, d2, fs}, 32'h0);
      rst_n = 1'b1;
      run_frames(1, 1'b0);

      // table: one digit lit per restart, various brightness levels
      foreach (vecs[k]) begin
         en = 1'b0;
         cyc(2);
         check("en_low_idle", {7'd0, sel, d1, d2, fs}, 32'h0);
         for (int i = 0; i < 8; i++) din[i] = 8'h00;
         din[vecs[k].digit] = vecs[k].code;
         bright = vecs[k].bright;
         mask   = 8'h00;
         en     = 1'b1;
         exp_sel = 8'(1 << vecs[k].digit);
         first = -1; cnt = 0;
         for (int n = 1; n <= FRAME; n++) begin
            cyc(1);
            hit = (sel == exp_sel) &&
                  (vecs[k].left ? (d1 == vecs[k].code && d2 == 8'h00)
                                : (d2 == vecs[k].code && d1 == 8'h00));
            if (hit) begin
               cnt++;
               if (first < 0) first = n;
            end
         end
         check("vec_first_lit", first, vecs[k].exp_first);
         check("vec_lit_cycles", cnt, vecs[k].exp_count);
      end

      // mid-frame data change is deferred to the next snapshot
      en = 1'b0;
      cyc(2);
      for (int i = 0; i < 8; i++) din[i] = 8'h00;
      din[5] = 8'h06; bright = 2'd3; mask = 8'h00; en = 1'b1;
      cyc(20);
      din[5] = 8'h5B;
      cyc(20);
      check("tear_sel_old",  {24'd0, sel}, 32'h20);
      check("tear_data_old", {24'd0, d1},  32'h06);
      cyc(89);
      check("tear_frame_start", {31'd0, fs}, 32'd1);
      cyc(41);
      check("tear_sel_new",  {24'd0, sel}, 32'h20);
      check("tear_data_new", {24'd0, d1},  32'h5B);

      // async reset mid-slot, then blink over six frames
      set_data(8'h76, 8'h3F);
      mask = 8'h01; bright = 2'd3;
      en = 1'b0;
      cyc(1);
      en = 1'b1;
      cyc(8);
      check("pre_reset_sel", {24'd0, sel}, 32'h80);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {7'd0, sel, d1, d2, fs}, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_frames(6, 1'b1);

      // drop en during digit 4
      cyc(56);
      check("digit4_active", {24'd0, sel}, 32'h10);
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         check("en_drop_outputs", {7'd0, sel, d1, d2, fs}, 32'h0);
      end
      en = 1'b1;
      cyc(1);
      check("en_rise_frame_start", {31'd0, fs}, 32'd1);
      check("en_rise_sel_dead", {24'd0, sel}, 32'h0);
      cyc(2);
      check("en_rise_digit7_sel",  {24'd0, sel}, 32'h80);
      check("en_rise_digit7_data", {24'd0, d1},  32'h76);

      // random stimulus against the model
      for (int k = 0; k < 3000; k++) begin
         cyc(1);
         if ($urandom_range(0, 99) < 2)  en = ~en;
         if ($urandom_range(0, 99) < 10) din[$urandom_range(0, 7)] = 8'($urandom);
         if ($urandom_range(0, 99) < 3)  mask = 8'($urandom);
         if ($urandom_range(0, 99) < 3)  bright = 2'($urandom);
      end
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
